// File: rtl/menu_renderer.sv
// rtl/menu_renderer.sv - menu navigation FSM with blinking highlight and 5x7 text renderer
//
// Ports:
//   clk, rst_n                         - system clock, asynchronous active-low reset
//   btn_up, btn_dn, btn_ok, btn_back   - single-cycle button pulses
//   pixel_index                        - OLED scan index (x = idx % 96, y = idx / 96)
//   pixel_data                         - registered RGB565 colour, one clk after pixel_index
//   str_item, str_pos, str_char        - lookup into the external label table (combinational)
//   sel_idx, sel_valid, confirmed      - current selection, confirm pulse, confirmed state

module menu_renderer #(
  parameter int          N_ITEMS   = 4,
  parameter int          ROW_H     = 16,
  parameter int          MAX_CHARS = 10,
  parameter int          BLINK_DIV = 25_000_000,
  parameter logic [15:0] FG_COLOR  = 16'hFFFF,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter logic [15:0] HL_COLOR  = 16'h07E0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        btn_ok,
  input  logic        btn_back,
  input  logic [12:0] pixel_index,
  output logic [15:0] pixel_data,
  output logic [2:0]  str_item,
  output logic [3:0]  str_pos,
  input  logic [7:0]  str_char,
  output logic [2:0]  sel_idx,
  output logic        sel_valid,
  output logic        confirmed
);

  localparam int          CW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [2:0]  LAST_ITEM = 3'(N_ITEMS - 1);
  localparam logic [12:0] ROW_H_W   = 13'(ROW_H);
  localparam logic [12:0] ROWS_END  = 13'(N_ITEMS * ROW_H);
  localparam logic [12:0] TEXT_TOP  = 13'((ROW_H - 7) / 2);
  localparam logic [12:0] MAX_K     = 13'(MAX_CHARS);

  typedef enum logic {NAV, CONFIRMED} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic          valid_d;
  logic          enter_confirm;
  logic [CW-1:0] blink_cnt;
  logic          blink_ph;

  // Font columns packed {col0..col4}; bit 0 of each column is the top glyph row.
  function automatic logic [34:0] font5x7(input logic [7:0] ch);
    logic [7:0] cu;
    cu = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    case (cu)
      "0": return {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
      "1": return {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
      "2": return {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
      "3": return {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
      "4": return {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
      "5": return {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
      "6": return {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
      "7": return {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
      "8": return {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      "9": return {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
      "A": return {7'h7C, 7'h12, 7'h11, 7'h12, 7'h7C};
      "B": return {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
      "C": return {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
      "D": return {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
      "E": return {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
      "F": return {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
      "G": return {7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A};
      "H": return {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
      "I": return {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
      "J": return {7'h20, 7'h40, 7'h41, 7'h3F, 7'h01};
      "K": return {7'h7F, 7'h08, 7'h14, 7'h22, 7'h41};
      "L": return {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
      "M": return {7'h7F, 7'h02, 7'h0C, 7'h02, 7'h7F};
      "N": return {7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F};
      "O": return {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
      "P": return {7'h7F, 7'h09, 7'h09, 7'h09, 7'h06};
      "Q": return {7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E};
      "R": return {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
      "S": return {7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
      "T": return {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01};
      "U": return {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F};
      "V": return {7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F};
      "W": return {7'h3F, 7'h40, 7'h38, 7'h40, 7'h3F};
      "X": return {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
      "Y": return {7'h07, 7'h08, 7'h70, 7'h08, 7'h07};
      "Z": return {7'h61, 7'h51, 7'h49, 7'h45, 7'h43};
      default: return 35'd0;
    endcase
  endfunction

  // Navigation FSM: btn_ok beats navigation; opposing up/dn cancel.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    valid_d       = 1'b0;
    enter_confirm = 1'b0;
    case (state_q)
      NAV: begin
        if (btn_ok) begin
          state_d       = CONFIRMED;
          valid_d       = 1'b1;
          enter_confirm = 1'b1;
        end else if (btn_up && !btn_dn) begin
          sel_d = (sel_q == 3'd0) ? LAST_ITEM : sel_q - 3'd1;
        end else if (btn_dn && !btn_up) begin
          sel_d = (sel_q == LAST_ITEM) ? 3'd0 : sel_q + 3'd1;
        end
      end
      CONFIRMED: begin
        if (btn_back) state_d = NAV;
      end
      default: state_d = NAV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NAV;
      sel_q     <= 3'd0;
      sel_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_valid <= valid_d;
    end
  end

  assign sel_idx   = sel_q;
  assign confirmed = (state_q == CONFIRMED);

  // Scan geometry and label lookup; kept apart from the glyph path because
  // str_char returns combinationally from str_item/str_pos.
  logic [12:0] px_x, px_y, px_row, px_ry, px_xo, px_k, px_c;
  logic        in_rows, in_cell;
  logic [2:0]  gr, gc;

  always_comb begin
    px_x    = pixel_index % 13'd96;
    px_y    = pixel_index / 13'd96;
    px_row  = px_y / ROW_H_W;
    px_ry   = px_y % ROW_H_W;
    px_xo   = px_x - 13'd5;
    px_k    = px_xo / 13'd6;
    px_c    = px_xo % 13'd6;
    in_rows = (pixel_index < 13'd6144) && (px_y < ROWS_END);
    in_cell = in_rows && (px_ry >= TEXT_TOP) && (px_ry < TEXT_TOP + 13'd7) &&
              (px_x >= 13'd5) && (px_c < 13'd5) && (px_k < MAX_K);
    gr       = 3'(px_ry - TEXT_TOP);
    gc       = px_c[2:0];
    str_item = in_cell ? px_row[2:0] : 3'd0;
    str_pos  = in_cell ? px_k[3:0]   : 4'd0;
  end

  logic [34:0] glyph;
  logic [6:0]  cols [0:7];
  logic        glyph_on, highlight;
  logic [15:0] pix_d;

  always_comb begin
    glyph = font5x7(str_char);
    for (int i = 0; i < 8; i++) cols[i] = 7'd0;
    for (int i = 0; i < 5; i++) cols[i] = glyph[(4 - i) * 7 +: 7];
    // Bold: OR each column with its right neighbour, except at the last column.
    glyph_on  = cols[gc][gr] | ((gc < 3'd4) ? cols[gc + 3'd1][gr] : 1'b0);
    highlight = (px_row == {10'd0, sel_q}) && ((state_q == NAV) || blink_ph);
    pix_d     = BG_COLOR;
    if (in_rows) begin
      pix_d = highlight ? HL_COLOR : BG_COLOR;
      if (in_cell && glyph_on) pix_d = highlight ? BG_COLOR : FG_COLOR;
    end
  end

  // Blink counter free-runs but restarts with the highlight visible on confirm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt  <= '0;
      blink_ph   <= 1'b1;
      pixel_data <= BG_COLOR;
    end else begin
      pixel_data <= pix_d;
      if (enter_confirm) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b1;
      end else if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_menu_renderer.sv
// tb/tb_menu_renderer.sv - randomized self-checking bench for menu_renderer

module tb_menu_renderer;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;
  localparam logic [15:0] HL = 16'h07E0;
  localparam int          BD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_dn = 1'b0, btn_ok = 1'b0, btn_back = 1'b0;
  logic [12:0] pixel_index = 13'd0;
  logic [15:0] pixel_data;
  logic [2:0]  str_item;
  logic [3:0]  str_pos;
  logic [7:0]  str_char;
  logic [2:0]  sel_idx;
  logic        sel_valid;
  logic        confirmed;

  logic [7:0] lab [0:7][0:15];
  assign str_char = lab[str_item][str_pos];

  menu_renderer #(.BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_dn(btn_dn), .btn_ok(btn_ok), .btn_back(btn_back),
    .pixel_index(pixel_index), .pixel_data(pixel_data),
    .str_item(str_item), .str_pos(str_pos), .str_char(str_char),
    .sel_idx(sel_idx), .sel_valid(sel_valid), .confirmed(confirmed)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int m_sel = 0;
  bit m_conf = 1'b0;
  int m_n = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic string pic(input logic [7:0] ch);
    string s;
    case (ch)
      "L": s = {"#....", "#....", "#....", "#....", "#....", "#....", "#####"};
      "O": s = {".###.", "#...#", "#...#", "#...#", "#...#", "#...#", ".###."};
      "A": s = {"..#..", ".#.#.", "#...#", "#...#", "#####", "#...#", "#...#"};
      "D": s = {"###..", "#..#.", "#...#", "#...#", "#...#", "#..#.", "###.."};
      "T": s = {"#####", "..#..", "..#..", "..#..", "..#..", "..#..", "..#.."};
      "E": s = {"#####", "#....", "#....", "####.", "#....", "#....", "#####"};
      default: s = "";
    endcase
    return s;
  endfunction

  function automatic bit pic_on(input logic [7:0] ch, input int row, input int col);
    string s;
    s = pic(ch);
    if (s.len() == 0) return 1'b0;
    return s[row * 5 + col] == "#";
  endfunction

  // Text cell containing idx, if any: row r, character k, glyph row/col.
  function automatic bit text_cell(input int idx, output int r, output int k,
                                   output int gy, output int gx);
    int x, y;
    r = 0; k = 0; gy = 0; gx = 0;
    if (idx >= 6144) return 1'b0;
    x = idx % 96;
    y = idx / 96;
    if (y >= 4 * 16 || x < 5) return 1'b0;
    r  = y / 16;
    gy = y % 16 - 4;
    k  = (x - 5) / 6;
    gx = (x - 5) % 6;
    if (gy < 0 || gy > 6 || gx == 5 || k >= 10) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] exp_pix(input int idx, input int sel, input bit conf, input bit ph);
    int r, k, gy, gx, y;
    bit hl, on;
    if (idx >= 6144) return BG;
    y = idx / 96;
    if (y >= 4 * 16) return BG;
    hl = (y / 16 == sel) && (!conf || ph);
    if (!text_cell(idx, r, k, gy, gx)) return hl ? HL : BG;
    on = pic_on(lab[r][k], gy, gx) || (gx < 4 && pic_on(lab[r][k], gy, gx + 1));
    if (on) return hl ? BG : FG;
    return hl ? HL : BG;
  endfunction

  task automatic cycle(input bit up, input bit dn, input bit ok, input bit back,
                       input logic [12:0] idx, input string tag);
    int r, k, gy, gx;
    bit ph, ev;
    logic [15:0] ep;
    btn_up = up; btn_dn = dn; btn_ok = ok; btn_back = back;
    pixel_index = idx;
    #1;
    if (text_cell(int'(idx), r, k, gy, gx)) begin
      check({tag, ".str_item"}, 16'(str_item), 16'(r));
      check({tag, ".str_pos"}, 16'(str_pos), 16'(k));
    end else begin
      check({tag, ".str_item_idle"}, 16'(str_item), 16'd0);
      check({tag, ".str_pos_idle"}, 16'(str_pos), 16'd0);
    end
    ph = ((m_n / BD) % 2) == 0;
    ep = exp_pix(int'(idx), m_sel, m_conf, ph);
    ev = 1'b0;
    if (!m_conf) begin
      if (ok) begin
        m_conf = 1'b1; ev = 1'b1; m_n = 0;
      end else if (up && !dn) m_sel = (m_sel + 3) % 4;
      else if (dn && !up)     m_sel = (m_sel + 1) % 4;
    end else begin
      m_n++;
      if (back) m_conf = 1'b0;
    end
    @(posedge clk); #1;
    btn_up = 1'b0; btn_dn = 1'b0; btn_ok = 1'b0; btn_back = 1'b0;
    check({tag, ".pixel_data"}, pixel_data, ep);
    check({tag, ".sel_idx"}, 16'(sel_idx), 16'(m_sel));
    check({tag, ".confirmed"}, 16'(confirmed), 16'(m_conf));
    check({tag, ".sel_valid"}, 16'(sel_valid), 16'(ev));
  endtask

  initial begin
    string names [0:3];
    names[0] = "LOAD"; names[1] = "LATE"; names[2] = "TOTAL"; names[3] = "DEAL";
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 16; j++) lab[i][j] = 8'h20;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < names[i].len(); j++) lab[i][j] = names[i][j];

    repeat (2) @(posedge clk);
    #1;
    check("reset.sel_idx", 16'(sel_idx), 16'd0);
    check("reset.confirmed", 16'(confirmed), 16'd0);
    check("reset.sel_valid", 16'(sel_valid), 16'd0);
    check("reset.pixel_data", pixel_data, BG);

    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 13'd0, "wrap_up_first_cycle");
    check("wrap_up_is_3", 16'(sel_idx), 16'd3);
    cycle(0, 1, 0, 0, 13'd100, "wrap_dn_1");
    cycle(0, 1, 0, 0, 13'd200, "wrap_dn_2");
    check("wrap_dn_is_1", 16'(sel_idx), 16'd1);
    cycle(1, 1, 0, 0, 13'd300, "up_dn_same_cycle");
    cycle(0, 1, 0, 0, 13'd400, "to_item_2");
    cycle(0, 1, 1, 0, 13'd500, "ok_beats_dn");
    check("confirm_valid", 16'(sel_valid), 16'd1);
    check("confirm_sel_2", 16'(sel_idx), 16'd2);

    for (int i = 0; i < 16; i++)
      cycle(i % 3 == 0, i % 3 == 1, i % 3 == 2, 0, 13'd3072, "blink");
    cycle(0, 0, 0, 1, 13'd0, "back");
    check("back_confirmed_0", 16'(confirmed), 16'd0);
    cycle(0, 0, 0, 1, 13'd0, "back_in_nav");

    cycle(1, 0, 0, 0, 13'd0, "nav_to_1");
    cycle(1, 0, 0, 0, 13'd0, "nav_to_0");
    cycle(0, 0, 0, 0, 13'd0, "hl_row0");
    check("hl_row0_const", pixel_data, HL);
    cycle(0, 0, 0, 0, 13'd1536, "row1_bg");
    check("row1_bg_const", pixel_data, BG);
    cycle(0, 0, 0, 0, 13'd1925, "glyph_L_x5");
    check("glyph_L_x5_const", pixel_data, FG);
    cycle(0, 0, 0, 0, 13'd1930, "glyph_gap_x10");
    check("glyph_gap_x10_const", pixel_data, BG);
    cycle(0, 0, 0, 0, 13'd6144, "index_6144");
    cycle(0, 0, 0, 0, 13'd8191, "index_8191");

    for (int i = 0; i < 400; i++) begin
      logic [12:0] idx;
      idx = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 8191))
                                        : 13'($urandom_range(0, 6143));
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, idx, "rand");
    end

    if (m_conf) cycle(0, 0, 0, 1, 13'd0, "pre_rst_back");
    if (m_sel == 0) cycle(0, 1, 0, 0, 13'd0, "pre_rst_nav");
    cycle(0, 0, 1, 0, 13'd0, "pre_rst_ok");
    #3 rst_n = 1'b0;
    #1;
    check("async_rst.confirmed", 16'(confirmed), 16'd0);
    check("async_rst.sel_idx", 16'(sel_idx), 16'd0);
    check("async_rst.sel_valid", 16'(sel_valid), 16'd0);
    check("async_rst.pixel_data", pixel_data, BG);
    btn_ok = 1'b1;
    @(posedge clk); #1;
    btn_ok = 1'b0;
    check("rst_held.sel_valid", 16'(sel_valid), 16'd0);
    check("rst_held.confirmed", 16'(confirmed), 16'd0);
    m_sel = 0; m_conf = 1'b0; m_n = 0;
    rst_n = 1'b1;
    cycle(0, 1, 0, 0, 13'd0, "post_rst_dn");
    check("post_rst_dn_is_1", 16'(sel_idx), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
